ula_sequencial: RTL and testbench
=================================

Name: ula_sequencial

Overview:
Parametrised sequential successor of the 4-bit combinational ULA. It performs add, sub, AND, OR, XOR, multiply and divide on WIDTH-bit operands under a start/busy/done handshake. Multiply uses iterative shift-add and divide uses iterative restoring division, each taking WIDTH cycles. Results and flags are registered and held for the downstream BCD/7-segment path; the sign output drives the sign digit.

Parameters:
WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; accepted only when busy=0
A_in  input  WIDTH  operand A, sampled on accept
B_in  input  WIDTH  operand B, sampled on accept
Cin  input  1  carry-in (add) / borrow-in (sub), sampled on accept
OP_sel  input  3  operation, sampled on accept
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
result  output  2*WIDTH  registered result
neg  output  1  signed-negative indication for the display sign digit
LED_Cout  output  1  carry/borrow out
LED_OV  output  1  signed overflow
LED_Z  output  1  result == 0 over all 2*WIDTH bits
LED_ERR  output  1  divide by zero

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state IDLE; busy, done, result, neg and all LED_* are 0; operand and counter registers are 0.
- FSM states:
  - IDLE: on start=1, latch A, B, Cin and OP_sel, then go to EXEC (busy=1 from the next cycle).
  - EXEC: compute.
  - On the final EXEC edge, write result and flags, pulse done=1 for one cycle, and return to IDLE (busy=0 in the same cycle as done).
- Back-to-back: start in the done cycle is accepted.
- start while busy=1 is ignored and has no side effects.
- Latency from accept edge k:
  - OP 000/001/010/011/100/111: result at edge k+1.
  - OP 101: result at edge k+WIDTH.
  - OP 110 with B!=0: result at edge k+WIDTH.
  - OP 110 with B==0: result at edge k+1.
- Opcode result rules (zero-extended into 2*WIDTH unless stated):
  - 000 add: A+B+Cin. LED_Cout = carry out. LED_OV = signed overflow (operands same sign, sum sign differs).
  - 001 sub: A-B-Cin. LED_Cout = borrow out. LED_OV = (A sign != B sign) and (diff sign != A sign). neg = diff MSB.
  - 010/011/100: bitwise AND/OR/XOR.
  - 101 mul: unsigned product, full 2*WIDTH bits. One shift-add step per cycle, LSB of multiplier first.
  - 110 div: unsigned. result[WIDTH-1:0] = quotient, result[2*WIDTH-1:WIDTH] = remainder. One restoring step per cycle.
  - 110 with B==0: LED_ERR=1, quotient=0, remainder=A.
  - 111: result 0, LED_Z=1.
- Flags not defined for an opcode are written 0 on completion (neg=0 except for sub).
- LED_Z is computed from the final result written.
- result and all flags hold their value until the next completion or reset; they never change mid-operation.
- Reset mid-operation aborts immediately to reset values; no done pulse.
- Inputs changing while busy have no effect.

Test Plan:
- WIDTH=8, add A=200 B=100 Cin=0 -> after 1 cycle: result=0x002C, LED_Cout=1, LED_OV=0, LED_Z=0, neg=0, done pulse of exactly 1 cycle.
- Sub A=5 B=9 Cin=0 -> result=0x00FC, LED_Cout=1, neg=1. Sub A=0x80 B=0x01 -> result=0x007F, LED_OV=1, neg=0.
- Mul A=15 B=17 -> busy 8 cycles, result=0x00FF. Mul A=255 B=255 -> result=0xFE01, LED_Z=0.
- Div A=100 B=7 -> after 8 cycles result=0x020E (rem 2, quo 14), LED_ERR=0. Div A=0x2A B=0 -> after 1 cycle result=0x2A00, LED_ERR=1.
- Mul in flight: pulse start with a new OP at cycle 3 -> ignored, original product delivered. Assert rst at cycle 4 -> outputs 0 immediately, no done pulse. Next start runs normally.
- OP=111 -> result=0, LED_Z=1. Start asserted in the done cycle -> accepted, second done pulse after the expected latency. Repeat with WIDTH=4 and WIDTH=16 at the corresponding boundary values.

Source files
------------

// File: rtl/ula_sequencial.sv
// Sequential ALU: add/sub/logic in one EXEC cycle, shift-add multiply and
// restoring divide in WIDTH EXEC cycles, with registered result and flags.
module ula_sequencial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  input  logic               Cin,
  input  logic [2:0]         OP_sel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic               LED_Cout,
  output logic               LED_OV,
  output logic               LED_Z,
  output logic               LED_ERR
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CLR = 3'b111
  } op_t;

  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  state_t             r_state;
  state_t             w_state_next;
  op_t                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;

  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_result;
  logic               r_neg;
  logic               r_cout;
  logic               r_ov;
  logic               r_z;
  logic               r_err;

  logic               w_accept;
  logic               w_iterative;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_trial;
  logic               w_q_bit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [2*WIDTH-1:0] w_res;
  logic               w_neg;
  logic               w_cout;
  logic               w_ov;
  logic               w_err;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_iterative = (r_op == OP_MUL) || ((r_op == OP_DIV) && (r_b != {WIDTH{1'b0}}));
  assign w_last      = (r_state == S_EXEC) &&
                       (!w_iterative || (r_cnt == CNT_W'(WIDTH - 1)));

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, r_cin};

  // One shift-add step; the final step's sum is the full product
  assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});

  // Restoring step: a clear bit WIDTH in the trial difference means it fits
  assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_trial = w_rem_sh - {1'b0, r_b};
  assign w_q_bit     = ~w_rem_trial[WIDTH];
  assign w_rem_next  = w_q_bit ? w_rem_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next  = {r_quo[WIDTH-2:0], w_q_bit};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EXEC: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Completion value and flags for the operation in flight
  always_comb begin
    w_res  = {(2*WIDTH){1'b0}};
    w_neg  = 1'b0;
    w_cout = 1'b0;
    w_ov   = 1'b0;
    w_err  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res  = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_cout = w_sum[WIDTH];
        w_ov   = add_overflow(r_a[WIDTH-1], r_b[WIDTH-1], w_sum[WIDTH-1]);
      end
      OP_SUB: begin
        w_res  = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_cout = w_diff[WIDTH];
        w_ov   = sub_overflow(r_a[WIDTH-1], r_b[WIDTH-1], w_diff[WIDTH-1]);
        w_neg  = w_diff[WIDTH-1];
      end
      OP_AND: w_res = {{WIDTH{1'b0}}, r_a & r_b};
      OP_OR:  w_res = {{WIDTH{1'b0}}, r_a | r_b};
      OP_XOR: w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
      OP_MUL: w_res = w_mul_acc;
      OP_DIV: begin
        if (r_b == {WIDTH{1'b0}}) begin
          w_res = {r_a, {WIDTH{1'b0}}};
          w_err = 1'b1;
        end else begin
          w_res = {w_rem_next, w_quo_next};
        end
      end
      OP_CLR:  w_res = {(2*WIDTH){1'b0}};
      default: w_res = {(2*WIDTH){1'b0}};
    endcase
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= OP_ADD;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_cin    <= 1'b0;
      r_cnt    <= {CNT_W{1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
      r_mcand  <= {(2*WIDTH){1'b0}};
      r_mplier <= {WIDTH{1'b0}};
      r_rem    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= {(2*WIDTH){1'b0}};
      r_neg    <= 1'b0;
      r_cout   <= 1'b0;
      r_ov     <= 1'b0;
      r_z      <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_EXEC);
      r_done <= w_last;
      if (w_accept) begin
        r_op     <= op_t'(OP_sel);
        r_a      <= A_in;
        r_b      <= B_in;
        r_cin    <= Cin;
        r_cnt    <= {CNT_W{1'b0}};
        r_acc    <= {(2*WIDTH){1'b0}};
        r_mcand  <= {{WIDTH{1'b0}}, A_in};
        r_mplier <= B_in;
        r_rem    <= {WIDTH{1'b0}};
        r_quo    <= A_in;
      end else if (r_state == S_EXEC) begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_acc    <= w_mul_acc;
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_rem    <= w_rem_next;
        r_quo    <= w_quo_next;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_last) begin
        r_result <= w_res;
        r_neg    <= w_neg;
        r_cout   <= w_cout;
        r_ov     <= w_ov;
        r_z      <= (w_res == {(2*WIDTH){1'b0}});
        r_err    <= w_err;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign neg      = r_neg;
  assign LED_Cout = r_cout;
  assign LED_OV   = r_ov;
  assign LED_Z    = r_z;
  assign LED_ERR  = r_err;

endmodule

// File: tb/tb_ula_sequencial.sv
// Scoreboard bench for ula_sequencial at WIDTH 4, 8 and 16; one instance is
// exercised at a time and a negedge monitor checks every done pulse.
module tb_ula_sequencial;

  typedef struct {
    int          inst;
    longint      acc;
    longint      done_cyc;
    logic [31:0] res;
    bit          neg;
    bit          cout;
    bit          ov;
    bit          z;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        cin_s;
  logic [2:0]  op_s;

  wire  [2:0]  busy_v, done_v, neg_v, cout_v, ov_v, z_v, err_v;
  wire  [7:0]  res4;
  wire  [15:0] res8;
  wire  [31:0] res16;

  longint cyc = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  exp_t   sbq[$];
  logic [37:0] prev_s[3];
  bit          prev_ok[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ula_sequencial #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A_in(a_s[3:0]), .B_in(b_s[3:0]),
    .Cin(cin_s), .OP_sel(op_s), .busy(busy_v[0]), .done(done_v[0]), .result(res4),
    .neg(neg_v[0]), .LED_Cout(cout_v[0]), .LED_OV(ov_v[0]), .LED_Z(z_v[0]), .LED_ERR(err_v[0]));

  ula_sequencial #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A_in(a_s[7:0]), .B_in(b_s[7:0]),
    .Cin(cin_s), .OP_sel(op_s), .busy(busy_v[1]), .done(done_v[1]), .result(res8),
    .neg(neg_v[1]), .LED_Cout(cout_v[1]), .LED_OV(ov_v[1]), .LED_Z(z_v[1]), .LED_ERR(err_v[1]));

  ula_sequencial #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A_in(a_s), .B_in(b_s),
    .Cin(cin_s), .OP_sel(op_s), .busy(busy_v[2]), .done(done_v[2]), .result(res16),
    .neg(neg_v[2]), .LED_Cout(cout_v[2]), .LED_OV(ov_v[2]), .LED_Z(z_v[2]), .LED_ERR(err_v[2]));

  function automatic int wid(int i);
    return (i == 0) ? 4 : ((i == 1) ? 8 : 16);
  endfunction

  function automatic logic [31:0] get_res(int i);
    case (i)
      0:       return {24'd0, res4};
      1:       return {16'd0, res8};
      default: return res16;
    endcase
  endfunction

  // Reference model: plain integer arithmetic on the operand values
  function automatic exp_t model(int w, logic [2:0] op, longint a, longint b, bit cin);
    exp_t   e;
    longint full = longint'(1) << w;
    longint m    = full - 1;
    longint h    = longint'(1) << (w - 1);
    longint sa   = (a >= h) ? a - full : a;
    longint sb   = (b >= h) ? b - full : b;
    longint t;
    e = '{default: 0};
    case (op)
      3'd0: begin
        t = a + b + longint'(cin);
        e.res  = 32'(t & m);
        e.cout = (t >= full);
        t = sa + sb + longint'(cin);
        e.ov   = (t >= h) || (t < -h);
      end
      3'd1: begin
        t = a - b - longint'(cin);
        e.cout = (t < 0);
        e.res  = 32'(t & m);
        e.neg  = e.res[w-1];
        e.ov   = ((a >= h) != (b >= h)) && (e.neg != (a >= h));
      end
      3'd2: e.res = 32'(a & b);
      3'd3: e.res = 32'(a | b);
      3'd4: e.res = 32'(a ^ b);
      3'd5: e.res = 32'(a * b);
      3'd6: begin
        if (b == 0) begin
          e.err = 1'b1;
          e.res = 32'(a << w);
        end else begin
          e.res = 32'(((a % b) << w) | (a / b));
        end
      end
      default: e.res = 32'd0;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic longint lat(int w, logic [2:0] op, longint b);
    return ((op == 3'd5) || ((op == 3'd6) && (b != 0))) ? longint'(w) : 64'sd1;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int idx, logic [2:0] op, longint a_in, longint b_in, bit cin, bit push);
    int     w = wid(idx);
    longint m = (longint'(1) << w) - 1;
    longint a = a_in & m;
    longint b = b_in & m;
    exp_t   e;
    a_s = 16'(a);
    b_s = 16'(b);
    cin_s = cin;
    op_s = op;
    start_v[idx] = 1'b1;
    if (push) begin
      e = model(w, op, a, b, cin);
      e.inst = idx;
      e.acc = cyc + 1;
      e.done_cyc = e.acc + lat(w, op, b);
      sbq.push_back(e);
    end
    step();
    start_v[idx] = 1'b0;
    a_s = 16'($urandom);
    b_s = 16'($urandom);
    cin_s = 1'($urandom);
    op_s = 3'($urandom);
  endtask

  task automatic wait_done(int idx);
    for (int n = 0; n < 100; n++) begin
      step();
      if (done_v[idx]) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic run(int idx, logic [2:0] op, longint a, longint b, bit cin);
    drive(idx, op, a, b, cin, 1'b1);
    wait_done(idx);
  endtask

  function automatic longint pick(int w);
    longint m = (longint'(1) << w) - 1;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return m;
      2:       return longint'(1) << (w - 1);
      default: return longint'($urandom) & m;
    endcase
  endfunction

  // Monitor: holds between completions, busy window, and scoreboard compare on done
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [37:0] cur;
    for (int i = 0; i < 3; i++) begin
      cur = {get_res(i), neg_v[i], cout_v[i], ov_v[i], z_v[i], err_v[i], 1'b0};
      if (!rst && prev_ok[i] && !done_v[i]) chk("hold_outputs", longint'(cur), longint'(prev_s[i]));
      prev_s[i] = cur;
      prev_ok[i] = 1'b1;
      if (!rst && (sbq.size() > 0) && (sbq[0].inst == i) && (cyc >= sbq[0].acc) && (cyc < sbq[0].done_cyc))
        chk("busy_during_op", longint'(busy_v[i]), 1);
      if (done_v[i]) begin
        if ((sbq.size() == 0) || (sbq[0].inst != i)) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done on instance %0d expected none at cycle %0d", i, cyc);
        end else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.done_cyc);
          chk("result", longint'(get_res(i)), longint'(e.res));
          chk("neg", longint'(neg_v[i]), longint'(e.neg));
          chk("LED_Cout", longint'(cout_v[i]), longint'(e.cout));
          chk("LED_OV", longint'(ov_v[i]), longint'(e.ov));
          chk("LED_Z", longint'(z_v[i]), longint'(e.z));
          chk("LED_ERR", longint'(err_v[i]), longint'(e.err));
          chk("busy_at_done", longint'(busy_v[i]), 0);
        end
      end
    end
  end

  task automatic check_zero(int i, string tag);
    chk({tag, "_result"}, longint'(get_res(i)), 0);
    chk({tag, "_flags"}, longint'({neg_v[i], cout_v[i], ov_v[i], z_v[i], err_v[i]}), 0);
    chk({tag, "_busy"}, longint'(busy_v[i]), 0);
    chk({tag, "_done"}, longint'(done_v[i]), 0);
  endtask

  initial begin
    int     w;
    longint m;
    longint h;
    logic [2:0] op;
    longint a;
    longint b;
    rst = 1'b1;
    start_v = 3'b000;
    a_s = 16'd0;
    b_s = 16'd0;
    cin_s = 1'b0;
    op_s = 3'd0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;
    step();

    for (int idx = 0; idx < 3; idx++) begin
      w = wid(idx);
      m = (longint'(1) << w) - 1;
      h = longint'(1) << (w - 1);

      // Directed cases, issued back-to-back in each done cycle
      run(idx, 3'd0, 200, 100, 1'b0);
      run(idx, 3'd0, m, 1, 1'b1);
      run(idx, 3'd0, h - 1, 1, 1'b0);
      run(idx, 3'd0, h, h, 1'b0);
      run(idx, 3'd1, 5, 9, 1'b0);
      run(idx, 3'd1, h, 1, 1'b0);
      run(idx, 3'd1, 0, 0, 1'b1);
      run(idx, 3'd1, m, m, 1'b0);
      run(idx, 3'd2, 16'hA5A5, 16'h0FF0, 1'b0);
      run(idx, 3'd3, 16'hA5A5, 16'h0FF0, 1'b0);
      run(idx, 3'd4, 16'hA5A5, 16'h0FF0, 1'b0);
      run(idx, 3'd5, 15, 17, 1'b0);
      run(idx, 3'd5, m, m, 1'b0);
      run(idx, 3'd5, 0, m, 1'b0);
      run(idx, 3'd6, 100, 7, 1'b0);
      run(idx, 3'd6, 16'h2A, 0, 1'b0);
      run(idx, 3'd6, m, 1, 1'b0);
      run(idx, 3'd6, 1, m, 1'b0);
      run(idx, 3'd7, m, m, 1'b1);

      // Start while busy must be ignored
      drive(idx, 3'd5, m - 2, m - 4, 1'b0, 1'b1);
      repeat (2) step();
      drive(idx, 3'd0, longint'($urandom), longint'($urandom), 1'b1, 1'b0);
      wait_done(idx);

      // Reset mid-multiply: immediate clear, no done pulse
      drive(idx, 3'd5, m, m, 1'b0, 1'b0);
      repeat (3) step();
      rst = 1'b1;
      #1;
      check_zero(idx, "abort");
      step();
      rst = 1'b0;
      repeat (2) step();
      chk("abort_idle_busy", longint'(busy_v[idx]), 0);

      for (int n = 0; n < 40; n++) begin
        op = 3'($urandom_range(0, 7));
        a = pick(w);
        b = pick(w);
        if ((op == 3'd6) && ($urandom_range(0, 3) == 0)) b = 0;
        run(idx, op, a, b, 1'($urandom));
        repeat ($urandom_range(0, 2)) step();
      end
      repeat (3) step();
    end

    for (int n = 0; (n < 200) && (sbq.size() > 0); n++) step();
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
